// File: rtl/pipe_stage_skid_reg.sv
// pipe_stage_skid_reg: valid/ready pipeline register with 2-entry skid buffer, flush and reset (optional stats: PIPE_STAGE_STATS_EN)
module pipe_stage_skid_reg #(
   parameter int CTRL_W = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0] data0_i,
   input  logic [DATA_W-1:0] data1_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] data0_o,
   output logic [DATA_W-1:0] data1_o,
   output logic [ADDR_W-1:0] addr_o
`ifdef PIPE_STAGE_STATS_EN
   ,
   output logic [15:0]       stall_cnt_o,
   output logic [15:0]       bubble_cnt_o
`endif
);
   localparam int E = CTRL_W + 2 * DATA_W + ADDR_W;
   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
   state_t            state_q, state_d;
   logic [E-1:0]      main_q, main_d, skid_q, skid_d, in_w;
   logic [CTRL_W-1:0] ctrl_w;
   logic              in_fire, out_fire;
   assign in_w     = {ctrl_i, data0_i, data1_i, addr_i};
   assign valid_o  = state_q != EMPTY;
   assign ready_o  = (state_q != FULL) & ~rst_i;
   assign in_fire  = valid_i & ready_o;
   assign out_fire = valid_o & ready_i;
   assign {ctrl_w, data0_o, data1_o, addr_o} = main_q;
   assign ctrl_o   = valid_o ? ctrl_w : '0;
   // next state: main always holds the oldest entry, skid only fills when main stalls
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: if (in_fire) begin
            main_d  = in_w;
            state_d = ONE;
         end
         ONE: begin
            if (in_fire && out_fire) main_d = in_w;
            else if (in_fire) begin
               skid_d  = in_w;
               state_d = FULL;
            end else if (out_fire) state_d = EMPTY;
         end
         FULL: if (out_fire) begin
            main_d  = skid_q;
            state_d = ONE;
         end
         default: state_d = EMPTY;
      endcase
      if (flush_i) begin
         state_d = EMPTY;
         main_d  = main_q;
         skid_d  = skid_q;
      end
   end
   // state and slot registers, fully cleared on reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end
`ifdef PIPE_STAGE_STATS_EN
   logic [15:0] stall_q, stall_d, bubble_q, bubble_d;
   assign stall_cnt_o  = stall_q;
   assign bubble_cnt_o = bubble_q;
   // saturating stall and bubble counters
   always_comb begin
      stall_d  = (valid_o & ~ready_i & ~&stall_q) ? stall_q + 16'd1 : stall_q;
      bubble_d = (flush_i & valid_o & ~&bubble_q) ? bubble_q + 16'd1 : bubble_q;
   end
   // counter registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else begin
         stall_q  <= stall_d;
         bubble_q <= bubble_d;
      end
   end
`endif
endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// tb_pipe_stage_skid_reg: directed plan plus random traffic against a queue model
module tb_pipe_stage_skid_reg;
   typedef struct packed {
      logic [3:0]  c;
      logic [31:0] d0;
      logic [31:0] d1;
      logic [4:0]  a;
   } ent_t;
   logic clk = 1'b0;
   logic rst_i = 1'b0, flush_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
   logic [3:0]  ctrl_i = '0, ctrl_o;
   logic [31:0] data0_i = '0, data1_i = '0, data0_o, data1_o;
   logic [4:0]  addr_i = '0, addr_o;
   logic        ready_o, valid_o;
`ifdef PIPE_STAGE_STATS_EN
   logic [15:0] stall_cnt_o, bubble_cnt_o;
`endif
   int   total = 0, bad = 0;
   ent_t q[$];
   bit   zeroed = 1'b1;
   int   stall_m = 0, bubble_m = 0;
   ent_t idle = '0;

   always #5 clk = ~clk;

   pipe_stage_skid_reg dut (
      .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
      .ctrl_i(ctrl_i), .data0_i(data0_i), .data1_i(data1_i), .addr_i(addr_i),
      .valid_o(valid_o), .ready_i(ready_i), .ctrl_o(ctrl_o), .data0_o(data0_o),
      .data1_o(data1_o), .addr_o(addr_o)
`ifdef PIPE_STAGE_STATS_EN
      , .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic ent_t mk(input logic [3:0] c, input logic [31:0] d0, input logic [31:0] d1, input logic [4:0] a);
      ent_t e;
      e.c = c; e.d0 = d0; e.d1 = d1; e.a = a;
      return e;
   endfunction

   task automatic check_out();
      chk("valid_o", 32'(valid_o), 32'(q.size() > 0));
      chk("ctrl_o", 32'(ctrl_o), q.size() > 0 ? 32'(q[0].c) : 32'd0);
      if (q.size() > 0) begin
         chk("data0_o", data0_o, q[0].d0);
         chk("data1_o", data1_o, q[0].d1);
         chk("addr_o", 32'(addr_o), 32'(q[0].a));
      end else if (zeroed) begin
         chk("data0_rst", data0_o, 32'd0);
         chk("data1_rst", data1_o, 32'd0);
         chk("addr_rst", 32'(addr_o), 32'd0);
      end
`ifdef PIPE_STAGE_STATS_EN
      chk("stall_cnt", 32'(stall_cnt_o), 32'(stall_m));
      chk("bubble_cnt", 32'(bubble_cnt_o), 32'(bubble_m));
`endif
   endtask

   task automatic cyc(input bit r, input bit f, input bit v, input bit rdy, input ent_t e);
      bit in_f, out_f;
      rst_i = r; flush_i = f; valid_i = v; ready_i = rdy;
      ctrl_i = e.c; data0_i = e.d0; data1_i = e.d1; addr_i = e.a;
      #1 chk("ready_o", 32'(ready_o), 32'(q.size() < 2 && !r));
      @(posedge clk);
      in_f  = v && q.size() < 2 && !r;
      out_f = q.size() > 0 && rdy;
      if (r) begin
         stall_m = 0; bubble_m = 0;
      end else begin
         if (q.size() > 0 && !rdy && stall_m < 65535) stall_m++;
         if (f && q.size() > 0 && bubble_m < 65535) bubble_m++;
      end
      if (r) begin
         q.delete();
         zeroed = 1'b1;
      end else if (f) q.delete();
      else begin
         if (out_f) void'(q.pop_front());
         if (in_f) begin
            q.push_back(e);
            zeroed = 1'b0;
         end
      end
      @(negedge clk);
      check_out();
   endtask

   initial begin
      @(negedge clk);
      cyc(1, 0, 0, 1, idle);
      cyc(0, 0, 1, 1, mk(4'b1001, 32'h11, 32'h22, 5'd3));
      cyc(0, 0, 1, 1, mk(4'b1001, 32'h12, 32'h23, 5'd4));
      cyc(0, 0, 0, 1, idle);
      cyc(0, 0, 0, 1, idle);
      cyc(0, 0, 1, 0, mk(4'hF, 32'hA, 32'h1, 5'd1));
      cyc(0, 0, 1, 0, mk(4'h3, 32'hB, 32'h2, 5'd2));
      cyc(0, 0, 1, 0, mk(4'h5, 32'hD, 32'h3, 5'd5));
      repeat (3) cyc(0, 0, 0, 1, idle);
      cyc(0, 0, 1, 0, mk(4'h7, 32'hA, 32'h4, 5'd6));
      cyc(0, 0, 1, 0, mk(4'h7, 32'hB, 32'h5, 5'd7));
      cyc(0, 1, 1, 0, mk(4'hE, 32'hC, 32'h6, 5'd8));
      cyc(0, 0, 0, 1, idle);
      cyc(0, 0, 1, 0, mk(4'h1, 32'h1, 32'h7, 5'd9));
      cyc(0, 0, 1, 0, mk(4'h2, 32'h2, 32'h8, 5'd10));
      cyc(1, 0, 1, 1, mk(4'h4, 32'h3, 32'h9, 5'd11));
      cyc(0, 0, 1, 1, mk(4'h8, 32'h4, 32'hA, 5'd31));
      cyc(0, 0, 0, 1, idle);
      cyc(0, 0, 1, 0, mk(4'h6, 32'h5, 32'hB, 5'd12));
      cyc(0, 0, 1, 1, mk(4'h9, 32'h6, 32'hC, 5'd13));
      cyc(0, 0, 0, 1, idle);
      cyc(1, 0, 0, 0, idle);
      cyc(0, 0, 1, 0, mk(4'hB, 32'h7, 32'hD, 5'd14));
      repeat (5) cyc(0, 0, 0, 0, idle);
      cyc(0, 1, 0, 1, idle);
`ifdef PIPE_STAGE_STATS_EN
      chk("stall_plan", 32'(stall_cnt_o), 32'd5);
      chk("bubble_plan", 32'(bubble_cnt_o), 32'd1);
      cyc(1, 0, 0, 1, idle);
      chk("stall_clr", 32'(stall_cnt_o), 32'd0);
      chk("bubble_clr", 32'(bubble_cnt_o), 32'd0);
`endif
      repeat (3000) begin
         ent_t e;
         e.c = 4'($urandom); e.d0 = $urandom; e.d1 = $urandom; e.a = 5'($urandom);
         cyc($urandom % 50 == 0, $urandom % 16 == 0, $urandom % 4 != 0, $urandom % 3 != 0, e);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
